// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Initiator side of the ALU interface. Takes one request at a
//                time, drives the ALU selects and, after the registered ALU
//                result arrives, returns it on a valid/ready response port.
//                SLE/SGE are built from two passes (LT/GT then EQ, OR-ed);
//                SNE is an inverted EQ.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int OP_WIDTH   = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [OP_WIDTH-1:0]   req_op,
   input  logic                  req_srca,
   input  logic [1:0]            req_srcb,
   output logic                  SrcA,
   output logic [1:0]            SrcB,
   output logic [OP_WIDTH-1:0]   AluOp,
   input  logic [DATA_WIDTH-1:0] alu_out,
   input  logic                  alu_overflow,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_overflow,
   output logic                  rsp_illegal
);

   localparam logic [OP_WIDTH-1:0] c_OP_IDLE = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] c_OP_SLT  = OP_WIDTH'(4);
   localparam logic [OP_WIDTH-1:0] c_OP_SGT  = OP_WIDTH'(5);
   localparam logic [OP_WIDTH-1:0] c_OP_SEQ  = OP_WIDTH'(6);
   localparam logic [OP_WIDTH-1:0] c_OP_SLE  = OP_WIDTH'(10);
   localparam logic [OP_WIDTH-1:0] c_OP_SGE  = OP_WIDTH'(11);
   localparam logic [OP_WIDTH-1:0] c_OP_SNE  = OP_WIDTH'(12);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_ISSUE2  = 3'd2,
      S_CAPTURE = 3'd3,
      S_RESP    = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [OP_WIDTH-1:0]   r_op;
   logic                  r_srca;
   logic [1:0]            r_srcb;
   logic                  r_tmp;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic                  r_rsp_overflow;
   logic                  r_rsp_illegal;

   logic                  w_accept;
   logic                  w_req_illegal;
   logic                  w_compound;
   logic [OP_WIDTH-1:0]   w_pass1_op;

   // Ops above SNE have no meaning; they are answered immediately as illegal.
   assign w_req_illegal = (req_op > c_OP_SNE);
   assign w_accept      = req_valid & req_ready;
   assign w_compound    = (r_op == c_OP_SLE) || (r_op == c_OP_SGE);

   // First ALU pass opcode: compound compares map onto native compare ops.
   always_comb begin
      w_pass1_op = r_op;
      case (r_op)
         c_OP_SLE: w_pass1_op = c_OP_SLT;
         c_OP_SGE: w_pass1_op = c_OP_SGT;
         c_OP_SNE: w_pass1_op = c_OP_SEQ;
         default:  w_pass1_op = r_op;
      endcase
   end

   // State register; reset from any state aborts the operation in flight.
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Request latch, first-pass bit and response registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_op           <= c_OP_IDLE;
         r_srca         <= 1'b0;
         r_srcb         <= 2'b00;
         r_tmp          <= 1'b0;
         r_rsp_data     <= '0;
         r_rsp_overflow <= 1'b0;
         r_rsp_illegal  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op           <= req_op;
            r_srca         <= req_srca;
            r_srcb         <= req_srcb;
            r_rsp_data     <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_illegal  <= w_req_illegal;
         end
         if (r_state == S_ISSUE2) begin
            r_tmp <= alu_out[0];
         end
         if (r_state == S_CAPTURE) begin
            if (w_compound) begin
               r_rsp_data     <= {{(DATA_WIDTH-1){1'b0}}, r_tmp | alu_out[0]};
               r_rsp_overflow <= 1'b0;
            end else if (r_op == c_OP_SNE) begin
               r_rsp_data     <= {{(DATA_WIDTH-1){1'b0}}, ~alu_out[0]};
               r_rsp_overflow <= 1'b0;
            end else begin
               r_rsp_data     <= alu_out;
               r_rsp_overflow <= alu_overflow;
            end
         end
      end
   end

   // Next-state and select/handshake outputs; reset forces idle outputs.
   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      SrcA        = 1'b0;
      SrcB        = 2'b00;
      AluOp       = c_OP_IDLE;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_state_nxt = w_req_illegal ? S_RESP : S_ISSUE;
         end
         S_ISSUE: begin
            SrcA        = r_srca;
            SrcB        = r_srcb;
            AluOp       = w_pass1_op;
            w_state_nxt = w_compound ? S_ISSUE2 : S_CAPTURE;
         end
         S_ISSUE2: begin
            SrcA        = r_srca;
            SrcB        = r_srcb;
            AluOp       = c_OP_SEQ;
            w_state_nxt = S_CAPTURE;
         end
         S_CAPTURE: begin
            SrcA        = r_srca;
            SrcB        = r_srcb;
            AluOp       = w_compound ? c_OP_SEQ : w_pass1_op;
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (reset) begin
         req_ready = 1'b0;
         rsp_valid = 1'b0;
         SrcA      = 1'b0;
         SrcB      = 2'b00;
         AluOp     = c_OP_IDLE;
      end
   end

   assign rsp_data     = r_rsp_data;
   assign rsp_overflow = r_rsp_overflow;
   assign rsp_illegal  = r_rsp_illegal;

endmodule
`default_nettype wire
